// File: rtl/alu_arbiter_if.sv
// Request/response bus between the two ALU requesters and the alu_arbiter.
// The master modport is the requester side; the slave modport is the arbiter.
interface alu_arbiter_if #(
    parameter int unsigned CNT_W = 16
);
    logic [1:0]       req_valid;
    logic [1:0]       req_ready;
    logic [7:0]       req_op0;
    logic [7:0]       req_op1;
    logic [31:0]      req_a0;
    logic [31:0]      req_a1;
    logic [31:0]      req_b0;
    logic [31:0]      req_b1;
    logic [1:0]       resp_valid;
    logic [1:0]       resp_ready;
    logic [31:0]      resp_data;
    logic             resp_err;
    logic             busy;
    logic [CNT_W-1:0] cnt0;
    logic [CNT_W-1:0] cnt1;

    modport master (
        output req_valid, req_op0, req_op1, req_a0, req_a1, req_b0, req_b1, resp_ready,
        input  req_ready, resp_valid, resp_data, resp_err, busy, cnt0, cnt1
    );

    modport slave (
        input  req_valid, req_op0, req_op1, req_a0, req_a1, req_b0, req_b1, resp_ready,
        output req_ready, resp_valid, resp_data, resp_err, busy, cnt0, cnt1
    );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one 32-bit ALU between two requesters.
// Each transaction: request handshake, one EXEC cycle, registered response.

// ALU: op[4:3] selects the unit, op[2:0] the function; unused codes return 0.
module alu_core (
    input  logic [4:0]  op_i,
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    output logic [31:0] res_c
);
    always_comb begin
        res_c = '0;
        case (op_i[4:3])
            2'd0: case (op_i[2:0])
                3'd0:    res_c = a_i + b_i;
                3'd1:    res_c = a_i - b_i;
                3'd2:    res_c = {31'b0, $signed(a_i) < $signed(b_i)};
                3'd3:    res_c = {31'b0, a_i < b_i};
                default: res_c = '0;
            endcase
            2'd1: case (op_i[2:0])
                3'd0:    res_c = a_i & b_i;
                3'd1:    res_c = a_i | b_i;
                3'd2:    res_c = a_i ^ b_i;
                3'd3:    res_c = ~(a_i | b_i);
                default: res_c = '0;
            endcase
            2'd2: case (op_i[2:0])
                3'd0:    res_c = a_i << b_i[4:0];
                3'd1:    res_c = a_i >> b_i[4:0];
                3'd2:    res_c = 32'($signed(a_i) >>> b_i[4:0]);
                default: res_c = '0;
            endcase
            default: case (op_i[2:0])
                3'd0:    res_c = a_i;
                3'd1:    res_c = b_i;
                default: res_c = '0;
            endcase
        endcase
    end
endmodule

module alu_arbiter #(
    parameter int unsigned CNT_W = 16
) (
    input logic          clk,
    input logic          rst,
    alu_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_e;

    state_e           state_q, state_d;
    logic             ptr_q, ptr_d;
    logic             owner_q, owner_d;
    logic [7:0]       op_q, op_d;
    logic [31:0]      a_q, a_d;
    logic [31:0]      b_q, b_d;
    logic [31:0]      resp_data_q, resp_data_d;
    logic             resp_err_q, resp_err_d;
    logic [1:0]       resp_valid_q, resp_valid_d;
    logic             busy_q, busy_d;
    logic [CNT_W-1:0] cnt0_q, cnt0_d;
    logic [CNT_W-1:0] cnt1_q, cnt1_d;
    logic [1:0]       grant_c;
    logic [31:0]      alu_res_c;

    // The ALU only ever sees the latched operands, never the live request bus.
    alu_core u_alu (
        .op_i  (op_q[4:0]),
        .a_i   (a_q),
        .b_i   (b_q),
        .res_c (alu_res_c)
    );

    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        owner_d      = owner_q;
        op_d         = op_q;
        a_d          = a_q;
        b_d          = b_q;
        resp_data_d  = resp_data_q;
        resp_err_d   = resp_err_q;
        resp_valid_d = resp_valid_q;
        busy_d       = busy_q;
        cnt0_d       = cnt0_q;
        cnt1_d       = cnt1_q;
        grant_c      = 2'b00;

        case (state_q)
            IDLE: begin
                case (bus.req_valid)
                    2'b01:   grant_c = 2'b01;
                    2'b10:   grant_c = 2'b10;
                    2'b11:   grant_c = ptr_q ? 2'b10 : 2'b01;
                    default: grant_c = 2'b00;
                endcase
                if (grant_c != 2'b00) begin
                    owner_d = grant_c[1];
                    ptr_d   = ~grant_c[1];
                    op_d    = grant_c[1] ? bus.req_op1 : bus.req_op0;
                    a_d     = grant_c[1] ? bus.req_a1  : bus.req_a0;
                    b_d     = grant_c[1] ? bus.req_b1  : bus.req_b0;
                    busy_d  = 1'b1;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                resp_data_d  = alu_res_c;
                resp_err_d   = |op_q[7:5];
                resp_valid_d = owner_q ? 2'b10 : 2'b01;
                state_d      = RESP;
            end
            RESP: begin
                // Only the owner's resp_ready retires the transaction.
                if (bus.resp_ready[owner_q]) begin
                    if (owner_q) cnt1_d = cnt1_q + CNT_W'(1);
                    else         cnt0_d = cnt0_q + CNT_W'(1);
                    resp_valid_d = 2'b00;
                    busy_d       = 1'b0;
                    state_d      = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            ptr_q        <= 1'b0;
            owner_q      <= 1'b0;
            op_q         <= '0;
            a_q          <= '0;
            b_q          <= '0;
            resp_data_q  <= '0;
            resp_err_q   <= 1'b0;
            resp_valid_q <= 2'b00;
            busy_q       <= 1'b0;
            cnt0_q       <= '0;
            cnt1_q       <= '0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            owner_q      <= owner_d;
            op_q         <= op_d;
            a_q          <= a_d;
            b_q          <= b_d;
            resp_data_q  <= resp_data_d;
            resp_err_q   <= resp_err_d;
            resp_valid_q <= resp_valid_d;
            busy_q       <= busy_d;
            cnt0_q       <= cnt0_d;
            cnt1_q       <= cnt1_d;
        end
    end

    assign bus.req_ready  = grant_c;
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_data  = resp_data_q;
    assign bus.resp_err   = resp_err_q;
    assign bus.busy       = busy_q;
    assign bus.cnt0       = cnt0_q;
    assign bus.cnt1       = cnt1_q;
endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: directed scenarios then random traffic, all checked
// against a transaction-level reference model.
module tb_alu_arbiter;
    localparam int unsigned CNT_W = 16;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    alu_arbiter_if #(.CNT_W(CNT_W)) bus ();
    alu_arbiter #(.CNT_W(CNT_W)) dut (.clk(clk), .rst(rst), .bus(bus));

    int n_vec = 0;
    int n_bad = 0;

    // Model: one in-flight transaction, its owner, cycles since grant, precomputed result.
    bit               m_busy;
    int               m_owner;
    int               m_age;
    int               m_prio;
    logic [31:0]      m_data;
    logic             m_err;
    logic [CNT_W-1:0] m_cnt [2];
    logic [1:0]       last_grant;
    int               grants [$];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] alu_ref(input logic [7:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
        int unsigned unit = int'(op[4:3]);
        int unsigned func = int'(op[2:0]);
        int unsigned sh   = int'(b[4:0]);
        if (unit == 0) begin
            if (func == 0) return a + b;
            if (func == 1) return a - b;
            if (func == 2) return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            if (func == 3) return (a < b) ? 32'd1 : 32'd0;
        end else if (unit == 1) begin
            if (func == 0) return a & b;
            if (func == 1) return a | b;
            if (func == 2) return a ^ b;
            if (func == 3) return ~(a | b);
        end else if (unit == 2) begin
            if (func == 0) return a << sh;
            if (func == 1) return a >> sh;
            if (func == 2) return 32'($signed(a) >>> sh);
        end else begin
            if (func == 0) return a;
            if (func == 1) return b;
        end
        return 32'd0;
    endfunction

    // One clock: check outputs just after the negedge drive, then advance the model.
    task automatic cycle();
        logic [1:0]  exp_rdy, exp_rv, rr;
        logic [7:0]  op;
        logic [31:0] a, b;
        logic        in_rst;
        #1;
        exp_rdy = 2'b00;
        if (!m_busy)
            exp_rdy = (bus.req_valid == 2'b11) ? ((m_prio != 0) ? 2'b10 : 2'b01) : bus.req_valid;
        exp_rv = (m_busy && m_age >= 1) ? ((m_owner != 0) ? 2'b10 : 2'b01) : 2'b00;
        chk("req_ready", bus.req_ready, exp_rdy);
        chk("resp_valid", bus.resp_valid, exp_rv);
        chk("busy", bus.busy, m_busy);
        chk("cnt0", bus.cnt0, m_cnt[0]);
        chk("cnt1", bus.cnt1, m_cnt[1]);
        if (exp_rv != 2'b00) begin
            chk("resp_data", bus.resp_data, m_data);
            chk("resp_err", bus.resp_err, m_err);
        end
        in_rst     = rst;
        rr         = bus.resp_ready;
        op         = exp_rdy[1] ? bus.req_op1 : bus.req_op0;
        a          = exp_rdy[1] ? bus.req_a1 : bus.req_a0;
        b          = exp_rdy[1] ? bus.req_b1 : bus.req_b0;
        last_grant = in_rst ? 2'b00 : exp_rdy;
        @(posedge clk);
        if (in_rst) begin
            m_busy = 0; m_prio = 0; m_cnt[0] = '0; m_cnt[1] = '0;
        end else if (!m_busy) begin
            if (exp_rdy != 2'b00) begin
                m_busy  = 1;
                m_owner = exp_rdy[1] ? 1 : 0;
                m_age   = 0;
                m_data  = alu_ref(op, a, b);
                m_err   = |op[7:5];
                m_prio  = 1 - m_owner;
                grants.push_back(m_owner);
            end
        end else if (m_age == 0) begin
            m_age = 1;
        end else if (rr[m_owner]) begin
            m_cnt[m_owner] = m_cnt[m_owner] + CNT_W'(1);
            m_busy = 0;
        end
        @(negedge clk);
    endtask

    function automatic logic [7:0] rand_op();
        logic [2:0] hi = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(1, 7)) : 3'b000;
        return {hi, 5'($urandom)};
    endfunction

    initial begin
        rst = 1'b1;
        bus.req_valid = 2'b00; bus.resp_ready = 2'b00;
        bus.req_op0 = '0; bus.req_op1 = '0;
        bus.req_a0 = '0; bus.req_a1 = '0; bus.req_b0 = '0; bus.req_b1 = '0;
        m_busy = 0; m_prio = 0; m_owner = 0; m_age = 0;
        m_data = '0; m_err = 1'b0; m_cnt[0] = '0; m_cnt[1] = '0;
        last_grant = 2'b00;
        @(posedge clk);
        @(negedge clk);
        cycle();

        // Single add from requester 0.
        rst = 1'b0;
        bus.req_valid = 2'b01; bus.req_op0 = 8'h00; bus.req_a0 = 32'd5; bus.req_b0 = 32'd7;
        bus.resp_ready = 2'b01;
        cycle();
        bus.req_valid = 2'b00;
        cycle();
        chk("s1_rv", bus.resp_valid, 2'b01);
        chk("s1_data", bus.resp_data, 32'd12);
        chk("s1_err", bus.resp_err, 1'b0);
        cycle();
        chk("s1_cnt0", bus.cnt0, 16'd1);

        // Both requesters continuously valid: grants alternate 0,1,0,1.
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        bus.req_valid = 2'b11; bus.resp_ready = 2'b11;
        bus.req_op0 = 8'h00; bus.req_a0 = 32'd1;   bus.req_b0 = 32'd2;
        bus.req_op1 = 8'h08; bus.req_a1 = 32'hFF;  bus.req_b1 = 32'h0F;
        grants.delete();
        repeat (12) cycle();
        chk("fair_n", 64'(grants.size()), 64'd4);
        for (int k = 0; k < 4 && k < grants.size(); k++)
            chk("fair_order", 64'(grants[k]), 64'(k % 2));
        chk("fair_cnt0", bus.cnt0, 16'd2);
        chk("fair_cnt1", bus.cnt1, 16'd2);

        // Owner 1 stalls its response while requester 0 waits.
        bus.req_valid = 2'b10; bus.resp_ready = 2'b00;
        cycle();
        bus.req_valid = 2'b01;
        repeat (6) cycle();
        bus.resp_ready = 2'b10;
        cycle();
        bus.resp_ready = 2'b00;
        #1 chk("stall_grant0", bus.req_ready, 2'b01);
        cycle();
        bus.req_valid = 2'b00; bus.resp_ready = 2'b01;
        repeat (3) cycle();

        // Erroneous opcode still evaluates op[4:0].
        bus.req_valid = 2'b01; bus.req_op0 = 8'hE1; bus.req_a0 = 32'd10; bus.req_b0 = 32'd3;
        bus.resp_ready = 2'b00;
        cycle();
        bus.req_valid = 2'b00;
        cycle();
        chk("err_data", bus.resp_data, 32'd7);
        chk("err_flag", bus.resp_err, 1'b1);
        bus.resp_ready = 2'b01;
        cycle();
        bus.req_valid = 2'b01; bus.req_op0 = 8'h01;
        cycle();
        bus.req_valid = 2'b00;
        cycle();
        chk("ok_data", bus.resp_data, 32'd7);
        chk("ok_flag", bus.resp_err, 1'b0);
        cycle();

        // Reset during EXEC discards the operation and the pointer.
        bus.req_valid = 2'b11; bus.resp_ready = 2'b11;
        cycle();
        rst = 1'b1; bus.req_valid = 2'b00;
        cycle();
        rst = 1'b0;
        chk("rst_rv", bus.resp_valid, 2'b00);
        chk("rst_cnt0", bus.cnt0, 16'd0);
        chk("rst_cnt1", bus.cnt1, 16'd0);
        bus.req_valid = 2'b11;
        #1 chk("rst_grant0", bus.req_ready, 2'b01);
        cycle();
        bus.req_valid = 2'b00;
        repeat (3) cycle();

        // Counter wrap from all-ones.
        m_cnt[0] = '1;
        force dut.cnt0_q = '1;
        cycle();
        release dut.cnt0_q;
        bus.req_valid = 2'b01; bus.req_op0 = 8'h00; bus.resp_ready = 2'b01;
        cycle();
        bus.req_valid = 2'b00;
        repeat (2) cycle();
        chk("wrap_cnt0", bus.cnt0, 16'd0);

        // Random traffic with legal request holding and occasional resets.
        for (int n = 0; n < 3000; n++) begin
            if (bus.req_valid[0] && !last_grant[0]) begin
                if ($urandom_range(0, 7) == 0) bus.req_valid[0] = 1'b0;
            end else begin
                bus.req_valid[0] = ($urandom_range(0, 2) != 0);
                bus.req_op0 = rand_op(); bus.req_a0 = $urandom; bus.req_b0 = $urandom;
            end
            if (bus.req_valid[1] && !last_grant[1]) begin
                if ($urandom_range(0, 7) == 0) bus.req_valid[1] = 1'b0;
            end else begin
                bus.req_valid[1] = ($urandom_range(0, 2) != 0);
                bus.req_op1 = rand_op(); bus.req_a1 = $urandom; bus.req_b1 = $urandom;
            end
            bus.resp_ready = 2'($urandom);
            rst = ($urandom_range(0, 299) == 0);
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares the single 32-bit ALU datapath between two independent requesters (port 0, port 1) using round-robin arbitration.
- Each transaction follows one path: valid/ready request handshake, operand registering, one-cycle ALU evaluation, registered result, valid/ready response handshake.
- Sits between the instruction-issue logic and the ALU instance. The ALU is instantiated inside this block, and no other block drives it.

Parameters:
- CNT_W, 16, width of the per-requester completed-operation counters.

Ports:
- clk  input  1  system clock, all state updates on rising edge
- rst  input  1  reset, synchronous, active-high
- req_valid  input  2  bit i: requester i presents an operation
- req_ready  output  2  bit i: arbiter accepts requester i's operation this cycle
- req_op0, req_op1  input  8 each  ALU opcode; [4:3] select unit, [2:0] func, [7:5] must be 0
- req_a0, req_a1  input  32 each  operand A
- req_b0, req_b1  input  32 each  operand B
- resp_valid  output  2  bit i: result for requester i available
- resp_ready  input  2  bit i: requester i consumes the result
- resp_data  output  32  registered ALU result (shared bus, qualified by resp_valid)
- resp_err  output  1  opcode[7:5] was nonzero for the returned operation
- busy  output  1  high in EXEC or RESP
- cnt0, cnt1  output  CNT_W each  completed responses per requester

Behaviour:
- Reset (synchronous, active-high) takes effect at the next clk edge and overrides all other activity:
  - state = IDLE; priority pointer = 0 (requester 0 favoured).
  - Operand/opcode registers, resp_data, resp_err and cnt0/cnt1 = 0.
  - req_ready = 0, resp_valid = 0, busy = 0.
  - An in-flight operation is discarded with no response; a handshake asserted in the reset cycle is ignored.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - req_ready is combinational. With one requester valid, it gets ready=1. With both valid, the requester equal to the pointer gets ready=1.
  - At most one req_ready bit is high in any cycle; req_ready = 0 in EXEC and RESP.
  - On the handshake edge: latch op/A/B and owner id, set pointer = ~owner, go to EXEC.
  - If neither requester is valid, stay in IDLE; the pointer is unchanged.
- EXEC (exactly 1 cycle):
  - The ALU is driven only from the latched registers.
  - At the edge: resp_data <= ALU output; resp_err <= |op[7:5]; go to RESP.
  - The ALU is still evaluated on an erroneous opcode using op[4:0].
- RESP:
  - resp_valid[owner] = 1, other bit 0; resp_data and resp_err are held stable.
  - On resp_ready[owner] = 1 at the edge: increment cnt[owner] (wraps at 2^CNT_W-1 -> 0), go to IDLE.
  - resp_ready of the non-owner is ignored.
- Latency:
  - Request handshake to resp_valid rising: 2 cycles.
  - Minimum issue interval: 3 cycles (IDLE, EXEC, RESP with immediate resp_ready).
- Combinational dependency: req_ready depends combinationally on req_valid, state and pointer only, never on resp_ready.
- Fairness: under continuous demand from both requesters, grants alternate 0,1,0,1; each requester waits at most one transaction.
- Request stability:
  - Requesters hold op/A/B stable while valid and not ready.
  - Deasserting valid before grant is legal and produces no transaction.
- Operand handling: width is fixed at 32 bits; the arbiter never modifies operands or the opcode.

Test Plan:
- Reset, then req_valid=01, op0=8'h00 (add), A=5, B=7, resp_ready=01 held:
  - req_ready=01 in the first cycle.
  - resp_valid=01 two cycles later with resp_data=12, resp_err=0.
  - cnt0=1.
- Both requesters valid from reset and resp_ready=11 held:
  - Grant order 0,1,0,1 over 4 transactions, 3 cycles apart.
  - cnt0=cnt1=2.
- Owner 1 in RESP with resp_ready=00 for 5 cycles, while req_valid=01 is asserted:
  - resp_valid=10 held; resp_data is constant; req_ready stays 00.
  - Requester 0 is granted the cycle after resp_ready[1] goes high and the FSM returns to IDLE.
- op0=8'hE1, A=10, B=3:
  - resp_err=1 and resp_data=7 (sub evaluated from op[4:0]).
  - The next op with op0=8'h01 returns resp_err=0.
- rst pulsed during EXEC:
  - No resp_valid afterwards; cnt0=cnt1=0; pointer=0.
  - With both requesters valid next, requester 0 is granted first.
- cnt0 preloaded to 16'hFFFF via 65535 completed ops (or a force in the bench), then one more completion -> cnt0 = 0.
